// File: rtl/txn_mem_resp.sv
// Memory responder for the fabric32 transaction port: read-only map region plus a
// path write region, programmable access latency, host preload/dump port and counters.
//
// state  | meaning
// -------+---------------------------------------------------------------
// S_IDLE | txn_rdy high, waiting for txn_req
// S_WAIT | transaction latched, cnt counting down to the completion edge
module txn_mem_resp #(
    parameter int          AW      = 7,
    parameter logic [31:0] RD_BASE = 32'h40000000,
    parameter logic [31:0] WR_BASE = 32'h40002000,
    parameter int          LATENCY = 4
) (
    input  logic          clk,
    input  logic          arst_n,
    input  logic          txn_req,
    input  logic          txn_wr,
    input  logic [31:0]   txn_addr,
    input  logic [31:0]   txn_wdata,
    output logic [31:0]   txn_rdata,
    output logic          txn_rdy,
    output logic          txn_err,
    input  logic          host_en,
    input  logic          host_we,
    input  logic          host_sel,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_wdata,
    output logic [31:0]   host_rdata,
    output logic [15:0]   rd_count,
    output logic [15:0]   wr_count
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam int          DEPTH        = 2 ** AW;
    localparam logic [31:0] REGION_BYTES = 32'(4 * DEPTH);
    localparam logic [4:0]  LAT          = 5'(LATENCY);

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        wr_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [15:0] rd_cnt_q, rd_cnt_d;
    logic [15:0] wr_cnt_q, wr_cnt_d;
    logic [31:0] host_rdata_q;

    logic [31:0] rd_mem [DEPTH];
    logic [31:0] wr_mem [DEPTH];

    logic          accept, complete, mem_we;
    logic          rd_hit, wr_hit;
    logic [AW-1:0] rd_idx, wr_idx;

    // Lower-bound compare keeps addresses below the base from wrapping into the region.
    always_comb begin
        rd_hit = (addr_q >= RD_BASE) && (addr_q < RD_BASE + REGION_BYTES) && (addr_q[1:0] == 2'b00);
        wr_hit = (addr_q >= WR_BASE) && (addr_q < WR_BASE + REGION_BYTES) && (addr_q[1:0] == 2'b00);
        rd_idx = AW'((addr_q - RD_BASE) >> 2);
        wr_idx = AW'((addr_q - WR_BASE) >> 2);
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept   = 1'b0;
        complete = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (txn_req) begin
                    accept  = 1'b1;
                    cnt_d   = LAT;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q != 5'd0) begin
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d  = rdata_q;
        err_d    = err_q;
        rd_cnt_d = rd_cnt_q;
        wr_cnt_d = wr_cnt_q;
        mem_we   = 1'b0;
        if (complete) begin
            if (wr_q) begin
                if (wr_hit) begin
                    mem_we   = 1'b1;
                    err_d    = 1'b0;
                    wr_cnt_d = (wr_cnt_q == 16'hFFFF) ? wr_cnt_q : wr_cnt_q + 16'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (rd_hit || wr_hit) begin
                rdata_d  = rd_hit ? rd_mem[rd_idx] : wr_mem[wr_idx];
                err_d    = 1'b0;
                rd_cnt_d = (rd_cnt_q == 16'hFFFF) ? rd_cnt_q : rd_cnt_q + 16'd1;
            end else begin
                rdata_d = 32'd0;
                err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= 5'd0;
            wr_q         <= 1'b0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            rd_cnt_q     <= 16'd0;
            wr_cnt_q     <= 16'd0;
            host_rdata_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
            if (accept) begin
                wr_q    <= txn_wr;
                addr_q  <= txn_addr;
                wdata_q <= txn_wdata;
            end
            if (host_en && !host_we) begin
                host_rdata_q <= host_sel ? wr_mem[host_addr] : rd_mem[host_addr];
            end
        end
    end

    // Transaction write is placed last so it wins a same-word collision with the host.
    always_ff @(posedge clk) begin
        if (host_en && host_we) begin
            if (host_sel) wr_mem[host_addr] <= host_wdata;
            else          rd_mem[host_addr] <= host_wdata;
        end
        if (mem_we) begin
            wr_mem[wr_idx] <= wdata_q;
        end
    end

    assign txn_rdy    = (state_q == S_IDLE);
    assign txn_rdata  = rdata_q;
    assign txn_err    = err_q;
    assign host_rdata = host_rdata_q;
    assign rd_count   = rd_cnt_q;
    assign wr_count   = wr_cnt_q;
endmodule

// File: doc/txn_mem_resp.md
# txn_mem_resp

Synthesizable memory responder for the fabric32 transaction port (`txn_req`/`txn_wr`/`txn_addr`/`txn_wdata`/`txn_rdata`/`txn_rdy`). It sits on the responder side of that port and provides two word-addressed regions:

- **Read region:** holds the grid/map the fabric reads.
- **Write region:** receives the paths the fabric writes.

Access time is programmable. A host-side port preloads the read region and dumps the write region. Saturating counters record transactions for software.

## Interface
Parameters:
- `AW`, 7, word-address width per region; each region is 2**AW 32-bit words.
- `RD_BASE`, 32'h40000000, byte base of read region.
- `WR_BASE`, 32'h40002000, byte base of write region.
- `LATENCY`, 4, extra wait cycles per transaction (0..31).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `arst_n`  in  1  asynchronous active-low reset.
- `txn_req`  in  1  transaction request from initiator.
- `txn_wr`  in  1  1 = write, 0 = read; sampled at accept.
- `txn_addr`  in  32  byte address; sampled at accept.
- `txn_wdata`  in  32  write data; sampled at accept.
- `txn_rdata`  out  32  read data; valid while `txn_rdy`=1 after a read.
- `txn_rdy`  out  1  1 = idle / previous transaction complete.
- `txn_err`  out  1  last completed transaction was out of range or misaligned.
- `host_en`  in  1  host access strobe.
- `host_we`  in  1  host write (1) / read (0).
- `host_sel`  in  1  0 = read region, 1 = write region.
- `host_addr`  in  AW  host word index.
- `host_wdata`  in  32  host write data.
- `host_rdata`  out  32  host read data; registered.
- `rd_count`  out  16  completed in-range reads, saturating at 16'hFFFF.
- `wr_count`  out  16  completed in-range writes, saturating at 16'hFFFF.

## Operation
- **FSM states:** IDLE and WAIT.
- **Accept:** a rising edge in IDLE with `txn_req`=1.
  - Latch `wr`, `addr` and `wdata`.
  - Load `cnt`=LATENCY, drive `txn_rdy`←0, go to WAIT.
- **WAIT with `cnt`≠0:** `cnt`←`cnt`−1.
- **WAIT with `cnt`=0 (completion edge):**
  - Perform the access.
  - Drive `txn_rdy`←1, update `txn_err`, go to IDLE.
- **Decode:**
  - `idx` = (`addr` − base) >> 2.
  - A region hit requires `addr` ≥ base, `addr` < base + 4·2**AW, and `addr[1:0]`=0. Subtraction is unsigned 32-bit; the `addr` ≥ base check is mandatory so wrap-around cannot alias.
  - Reads hit either region; the read region is checked first.
  - Writes hit the write region only. The read region is read-only to the transaction port.
- **Hit:** read loads `txn_rdata` with the word and increments `rd_count`; write stores `wdata` and increments `wr_count`. Set `txn_err`←0.
- **Miss:** no memory change and no count change. Set `txn_err`←1; a read loads `txn_rdata`←0.
- `txn_rdata` and `txn_err` hold their values until the next completion edge.
- **Host port:**
  - `host_en`&`host_we` writes the selected region at `host_addr` on that edge.
  - `host_en`&!`host_we` loads `host_rdata` on that edge.
  - The host port is independent of FSM state.
- **Collision:** host write and a completing transaction write to the same write-region word on the same edge → transaction data wins.
- **Reset values:**
  - State IDLE, `cnt`=0.
  - `txn_rdy`=1, `txn_rdata`=0, `txn_err`=0, `host_rdata`=0, `rd_count`=0, `wr_count`=0.
  - Memory contents are not reset.
- **Reset mid-transaction:** the transaction is abandoned with no memory write and no count change; `txn_rdy`=1 immediately (asynchronous).

## Timing
- Accept at edge E0 → `txn_rdy`=0 from E0 through E0+LATENCY. The completion edge is E0+LATENCY+1, where `txn_rdy`=1 and data/err are valid.
- With LATENCY=0, `txn_rdy` is low for exactly one cycle.
- `txn_req` is ignored in WAIT.
- `txn_req` held high continuously → the next accept is at the edge after completion. Throughput is one transaction per LATENCY+2 cycles.
- Initiator rule: after `txn_rdy` rises, drop `txn_req` before the next edge or present the next transaction.
- Host read latency is 1 edge; host write takes effect at the strobe edge.
- Counter saturation: at 16'hFFFF the counter holds; no wrap.

## Test plan
- **Reset:** `arst_n`=0 → `txn_rdy`=1, `txn_rdata`=0, `txn_err`=0, `rd_count`=`wr_count`=0, with no clock required.
- **Host preload and read:** preload read-region word 5 = 32'hDEADBEEF via host, then read 32'h40000014 accepted at E0 (LATENCY=4).
  - `txn_rdy` is low E0..E4.
  - At E5: `txn_rdy`=1, `txn_rdata`=32'hDEADBEEF, `txn_err`=0, `rd_count`=1.
- **Write and host readback:** write 32'h40002008 data 32'h12345678.
  - After completion, `wr_count`=1.
  - Host read with `host_sel`=1, `host_addr`=2 → `host_rdata`=32'h12345678 one edge later.
- **Error cases:**
  - Write to 32'h40000000 → `txn_err`=1, read-region word 0 unchanged, `wr_count` unchanged.
  - Read 32'h40000002 → `txn_err`=1, `txn_rdata`=0.
  - Read 32'h3FFFFFFC → `txn_err`=1.
- **Reset mid-transaction:** assert `arst_n`=0 during WAIT of a write to 32'h40002010 → `txn_rdy`=1 immediately; the word stays at its prior value.
- **Back-to-back and collision:**
  - `txn_req` held high for two writes → accepts spaced exactly 6 cycles apart.
  - Host write of 32'hAAAA0000 to write-region word 3 on the completion edge of a transaction write of 32'h5555FFFF to 32'h4000200C → word 3 = 32'h5555FFFF.
